// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and channel-index width helper for rr_arb_mux.
package mux_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int NCH_DEF = 4;
   function automatic int chw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: round-robin grant starting one past last_grant, wrapping; one-hot grant plus index.
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] last_grant,
   input  logic           enable,
   output logic [NCH-1:0] grant,
   output logic [CHW-1:0] grant_idx
);
   logic           w_found;
   logic [CHW-1:0] w_j;
   always_comb begin
      w_found = 1'b0;
      w_j = '0;
      grant_idx = '0;
      for (int k = 1; k <= NCH; k++) begin
         w_j = CHW'((int'(last_grant) + k) % NCH);
         if (!w_found && req[w_j]) begin
            w_found = 1'b1;
            grant_idx = w_j;
         end
      end
      grant = (enable && w_found) ? NCH'(1) << grant_idx : '0;
   end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin NCH:1 mux with 1-cycle registered output.
// RR_ARB_MUX_SKID_EN adds a 2-entry skid buffer so in_ready never depends on out_ready.
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NCH = NCH_DEF,
   localparam int CHW = chw(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CHW-1:0]       out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);
   logic [CHW-1:0]   r_last;
   logic [CHW-1:0]   w_idx;
   logic [NCH-1:0]   w_grant;
   logic             w_enable;
   logic             w_xfer;
   logic [WIDTH-1:0] w_sel;

   rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
      .req(in_valid),
      .last_grant(r_last),
      .enable(w_enable),
      .grant(w_grant),
      .grant_idx(w_idx)
   );

   assign in_ready = w_grant;
   assign w_xfer = |w_grant;
   assign w_sel = in_data[w_idx*WIDTH +: WIDTH];

   // Priority only advances on a real transfer, never on a stalled grant
   always_ff @(posedge clk)
      if (rst) r_last <= CHW'(NCH - 1);
      else if (w_xfer) r_last <= w_idx;

`ifdef RR_ARB_MUX_SKID_EN
   logic [1:0][CHW+WIDTH-1:0] r_sk;
   logic [1:0]                r_sk_cnt;
   logic                      w_load;
   logic                      w_from_sk;
   logic                      w_to_sk;

   assign w_enable = !rst && r_sk_cnt != 2'd2;
   assign w_load = !out_valid || out_ready;
   assign w_from_sk = w_load && r_sk_cnt != 2'd0;
   assign w_to_sk = w_xfer && !(w_load && r_sk_cnt == 2'd0);

   // Output register refills from the skid head first to keep arrival order
   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_ch <= '0;
         r_sk_cnt <= 2'd0;
      end else begin
         if (w_from_sk) {out_ch, out_data} <= r_sk[0];
         else if (w_load && w_xfer) {out_ch, out_data} <= {w_idx, w_sel};
         if (w_load) out_valid <= w_from_sk || w_xfer;
         if (w_from_sk) r_sk[0] <= r_sk[1];
         if (w_to_sk) r_sk[r_sk_cnt[0] & !w_from_sk] <= {w_idx, w_sel};
         r_sk_cnt <= r_sk_cnt + {1'b0, w_to_sk} - {1'b0, w_from_sk};
      end
`else
   assign w_enable = !rst && (!out_valid || out_ready);

   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_ch <= '0;
      end else if (w_xfer) begin
         out_data <= w_sel;
         out_ch <= w_idx;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: table-driven and randomized checks of rr_arb_mux against a queue-based model.
module tb_rr_arb_mux;
   localparam int W = 32;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_ch;
   logic           out_valid;
   logic           out_ready = 1'b0;

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_ch(out_ch),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   int           n_tests = 0;
   int           n_fail = 0;
   logic [W-1:0] dat[N];
   int           lastg;
   logic [W-1:0] qd[$];
   int           qc[$];
   logic [W-1:0] shown_d;
   int           shown_c;

   typedef struct {
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] ch;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v);
      for (int k = 1; k <= N; k++)
         if (((v >> ((lastg + k) % N)) & 4'd1) != 4'd0) return (lastg + k) % N;
      return -1;
   endfunction

   // Model: words sit in a FIFO; front is what the output shows
   task automatic step(input logic [N-1:0] iv, input logic ordy, input string tag, output logic [N-1:0] got);
      bit         can;
      int         g;
      logic [N-1:0] er;
      @(negedge clk);
      in_valid = iv;
      out_ready = ordy;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
      #1;
`ifdef RR_ARB_MUX_SKID_EN
      can = qd.size() <= 2;
`else
      can = qd.size() == 0 || ordy;
`endif
      g = rr_pick(iv);
      er = (can && g >= 0) ? (4'd1 << g) : 4'd0;
      got = in_ready;
      chk({tag, ".in_ready"}, in_ready, er);
`ifdef RR_ARB_MUX_SKID_EN
      out_ready = !ordy;
      #1;
      chk({tag, ".rdy_indep"}, in_ready, er);
      out_ready = ordy;
      #1;
`endif
      @(posedge clk);
      if (qd.size() > 0 && ordy) begin
         void'(qd.pop_front());
         void'(qc.pop_front());
      end
      if (er != 0) begin
         qd.push_back(dat[g]);
         qc.push_back(g);
         lastg = g;
      end
      if (qd.size() > 0) begin
         shown_d = qd[0];
         shown_c = qc[0];
      end
      #1;
      chk({tag, ".out_valid"}, out_valid, qd.size() > 0);
      chk({tag, ".out_data"}, out_data, shown_d);
      chk({tag, ".out_ch"}, out_ch, shown_c[1:0]);
   endtask

   task automatic do_reset(input logic ordy, input string tag);
      @(negedge clk);
      rst = 1'b1;
      in_valid = '1;
      out_ready = ordy;
      #1;
      chk({tag, ".rst_in_ready"}, in_ready, 0);
      @(posedge clk);
      #1;
      chk({tag, ".rst_out_valid"}, out_valid, 0);
      chk({tag, ".rst_out_data"}, out_data, 0);
      chk({tag, ".rst_out_ch"}, out_ch, 0);
      qd.delete();
      qc.delete();
      lastg = N - 1;
      shown_d = '0;
      shown_c = 0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] got;
      logic [W-1:0] held_d;
      logic [1:0]   held_c;
      for (int i = 0; i < N; i++) dat[i] = 32'h1000_0000 + W'(i);
      dat[2] = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 1'b1, 4'd1 << (i % 4), 1'b1, 2'(i % 4)};
      tbl[8]  = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd3};
      tbl[9]  = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1};
      tbl[10] = '{4'h8, 1'b1, 4'h8, 1'b1, 2'd3};
      tbl[11] = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1};
      tbl[12] = '{4'h8, 1'b1, 4'h8, 1'b1, 2'd3};
      tbl[13] = '{4'h4, 1'b1, 4'h4, 1'b1, 2'd2};
      tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd2};
      repeat (2) @(posedge clk);
      do_reset(1'b1, "init");

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].iv, tbl[i].ordy, "tbl", got);
         chk($sformatf("tbl%0d.rdy", i), got, tbl[i].rdy);
         chk($sformatf("tbl%0d.ov", i), out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d.ch", i), out_ch, tbl[i].ch);
         if (i == 13) chk("tbl.deadbeef", out_data, 32'hDEAD_BEEF);
      end

      // Stall with everything valid; priority must not move while held
      step(4'hF, 1'b1, "hold", got);
      held_d = out_data;
      held_c = out_ch;
      for (int i = 0; i < 5; i++) begin
         step(4'hF, 1'b0, "hold", got);
`ifndef RR_ARB_MUX_SKID_EN
         chk("hold.in_ready_low", got, 4'h0);
         chk("hold.data_stable", out_data, held_d);
         chk("hold.ch_stable", out_ch, held_c);
`endif
      end
      step(4'hF, 1'b1, "release", got);
`ifndef RR_ARB_MUX_SKID_EN
      chk("release.next_grant", got, 4'd1 << ((held_c + 2'd1) % 4));
`endif

      repeat (3) step(4'h0, 1'b1, "drain", got);
      dat[1] = 32'h1234_5678;
      step(4'h2, 1'b1, "pre_rst", got);
      chk("pre_rst.data", out_data, 32'h1234_5678);
      do_reset(1'b0, "mid");
      step(4'hF, 1'b1, "post_rst", got);
      chk("post_rst.first_grant", got, 4'h1);

      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) dat[i] = $urandom;
         step(4'($urandom), $urandom_range(0, 3) != 0, "rand", got);
      end
      do_reset(1'b1, "rand_rst");

      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) dat[i] = $urandom;
         step(4'hF, c[0], "toggle", got);
      end
      repeat (4) step(4'h0, 1'b1, "final_drain", got);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
